// File: rtl/reg_gp_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_gp_file
// Brief    : GP register file; one writeback port, two registered read ports
//            with write-first bypass, and a post-reset clear sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module reg_gp_file #(
    parameter int P_DATA_W = 24,
    parameter int P_ADDR_W = 4
) (
    input  logic                iw_clk,
    input  logic                iw_rst_n,
    input  logic                iw_write_enable,
    input  logic [P_ADDR_W-1:0] iw_write_addr,
    input  logic [P_DATA_W-1:0] iw_write_data,
    input  logic                iw_rd_en_a,
    input  logic [P_ADDR_W-1:0] iw_rd_addr_a,
    output logic [P_DATA_W-1:0] ow_rd_data_a,
    input  logic                iw_rd_en_b,
    input  logic [P_ADDR_W-1:0] iw_rd_addr_b,
    output logic [P_DATA_W-1:0] ow_rd_data_b,
    output logic                ow_ready
);

    localparam int                  DEPTH    = 2**P_ADDR_W;
    localparam logic [P_ADDR_W-1:0] LAST_IDX = {P_ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                state_q;
    logic [P_ADDR_W-1:0]   cnt_q;
    logic                  ready_q;
    logic [P_DATA_W-1:0]   rd_data_a_q;
    logic [P_DATA_W-1:0]   rd_data_b_q;
    logic [P_DATA_W-1:0]   mem_q [DEPTH];

    logic                  mem_we_d;
    logic [P_ADDR_W-1:0]   mem_waddr_d;
    logic [P_DATA_W-1:0]   mem_wdata_d;
    logic [P_DATA_W-1:0]   rd_data_a_d;
    logic [P_DATA_W-1:0]   rd_data_b_d;
    logic                  bypass_a;
    logic                  bypass_b;

    // The init sequencer owns the write port until the array is cleared.
    always_comb begin
        mem_we_d    = 1'b0;
        mem_waddr_d = iw_write_addr;
        mem_wdata_d = iw_write_data;
        if (state_q == S_INIT) begin
            mem_we_d    = 1'b1;
            mem_waddr_d = cnt_q;
            mem_wdata_d = '0;
        end else if (state_q == S_RUN) begin
            mem_we_d    = iw_write_enable;
        end
    end

    assign bypass_a    = (state_q == S_RUN) && iw_write_enable && (iw_write_addr == iw_rd_addr_a);
    assign bypass_b    = (state_q == S_RUN) && iw_write_enable && (iw_write_addr == iw_rd_addr_b);
    assign rd_data_a_d = bypass_a ? iw_write_data : mem_q[iw_rd_addr_a];
    assign rd_data_b_d = bypass_b ? iw_write_data : mem_q[iw_rd_addr_b];

    // No reset on the array so it can map onto RAM.
    always_ff @(posedge iw_clk) begin
        if (mem_we_d) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q     <= S_INIT;
                    cnt_q       <= '0;
                    ready_q     <= 1'b0;
                    rd_data_a_q <= '0;
                    rd_data_b_q <= '0;
                end
                S_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_q <= S_RUN;
                        ready_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (iw_rd_en_a) begin
                        rd_data_a_q <= rd_data_a_d;
                    end
                    if (iw_rd_en_b) begin
                        rd_data_b_q <= rd_data_b_d;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign ow_rd_data_a = rd_data_a_q;
    assign ow_rd_data_b = rd_data_b_q;
    assign ow_ready     = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_gp_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_gp_file
// Brief    : Directed-vector bench for reg_gp_file with a queued scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_gp_file;

    localparam int DW = 24;
    localparam int AW = 4;

    logic          clk;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          ena;
    logic [AW-1:0] aa;
    logic [DW-1:0] da;
    logic          enb;
    logic [AW-1:0] ab;
    logic [DW-1:0] db;
    logic          rdy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          port;
        logic [31:0] val;
        string       nm;
    } exp_t;

    exp_t sb[$];

    reg_gp_file #(.P_DATA_W(DW), .P_ADDR_W(AW)) dut (
        .iw_clk          (clk),
        .iw_rst_n        (rst_n),
        .iw_write_enable (we),
        .iw_write_addr   (wa),
        .iw_write_data   (wd),
        .iw_rd_en_a      (ena),
        .iw_rd_addr_a    (aa),
        .ow_rd_data_a    (da),
        .iw_rd_en_b      (enb),
        .iw_rd_addr_b    (ab),
        .ow_rd_data_b    (db),
        .ow_ready        (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input int port, input logic [31:0] val, input string nm);
        exp_t e;
        e.port = port;
        e.val  = val;
        e.nm   = nm;
        sb.push_back(e);
    endtask

    // Drive one cycle of inputs and queue what the DUT must show after the edge.
    task automatic cyc(input logic w, input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
                       input logic ea, input logic [AW-1:0] ra,
                       input logic eb, input logic [AW-1:0] rb,
                       input logic [DW-1:0] xa, input logic [DW-1:0] xb,
                       input logic xr, input string nm);
        @(negedge clk);
        we  = w;   wa = waddr; wd = wdata;
        ena = ea;  aa = ra;
        enb = eb;  ab = rb;
        push(0, {8'h0, xa}, {nm, "_a"});
        push(1, {8'h0, xb}, {nm, "_b"});
        push(2, {31'h0, xr}, {nm, "_rdy"});
    endtask

    // Release reset away from any edge and walk the clear sequence.
    task automatic init_seq(input string tag, input bit pulse_write);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            if (pulse_write && k == 10)
                cyc(1'b1, 4'd5, 24'h0000FF, 1'b1, 4'd5, 1'b1, 4'd5, 24'h0, 24'h0, 1'b0, {tag, "_initwr"});
            else
                cyc(1'b0, 4'd0, 24'h0, 1'b1, 4'd5, 1'b1, AW'(k), 24'h0, 24'h0, (k == 17), {tag, "_init"});
        end
    endtask

    // Monitor: after each rising edge, retire everything queued for that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                case (e.port)
                    0:       chk(e.nm, {8'h0, da}, e.val);
                    1:       chk(e.nm, {8'h0, db}, e.val);
                    default: chk(e.nm, {31'h0, rdy}, e.val);
                endcase
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        we = 1'b0; wa = '0; wd = '0;
        ena = 1'b0; aa = '0; enb = 1'b0; ab = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready", {31'h0, rdy}, 32'h0);
        chk("rst_rd_a", {8'h0, da}, 32'h0);
        chk("rst_rd_b", {8'h0, db}, 32'h0);

        init_seq("boot", 1'b1);

        for (int i = 0; i < 16; i++)
            cyc(1'b0, 4'd0, 24'h0, 1'b1, AW'(i), 1'b1, AW'(15 - i), 24'h0, 24'h0, 1'b1, "clear_scan");

        cyc(1'b1, 4'd3, 24'h00A5A5, 1'b0, 4'd3, 1'b0, 4'd3, 24'h0, 24'h0, 1'b1, "wr_r3");
        cyc(1'b0, 4'd0, 24'h0, 1'b1, 4'd3, 1'b0, 4'd3, 24'h00A5A5, 24'h0, 1'b1, "rd_r3");

        cyc(1'b1, 4'd7, 24'h123456, 1'b1, 4'd7, 1'b1, 4'd7, 24'h123456, 24'h123456, 1'b1, "bypass_r7");
        cyc(1'b0, 4'd0, 24'h0, 1'b1, 4'd7, 1'b1, 4'd3, 24'h123456, 24'h00A5A5, 1'b1, "rd_r7_r3");

        cyc(1'b1, 4'd2, 24'h000011, 1'b0, 4'd0, 1'b1, 4'd2, 24'h123456, 24'h000011, 1'b1, "wr_r2_byp_b");
        cyc(1'b0, 4'd0, 24'h0, 1'b0, 4'd0, 1'b0, 4'd7, 24'h123456, 24'h000011, 1'b1, "hold_b7");
        cyc(1'b0, 4'd0, 24'h0, 1'b1, 4'd2, 1'b0, 4'd3, 24'h000011, 24'h000011, 1'b1, "hold_b3");

        cyc(1'b1, 4'd9, 24'hABCDEF, 1'b1, 4'd9, 1'b1, 4'd8, 24'hABCDEF, 24'h0, 1'b1, "byp_a_only");
        cyc(1'b1, 4'd0, 24'h000001, 1'b1, 4'd9, 1'b1, 4'd0, 24'hABCDEF, 24'h000001, 1'b1, "wr_r0_byp_b");
        cyc(1'b1, 4'd15, 24'hFFFFFF, 1'b1, 4'd0, 1'b1, 4'd14, 24'h000001, 24'h0, 1'b1, "wr_r15");
        cyc(1'b0, 4'd0, 24'h0, 1'b1, 4'd15, 1'b1, 4'd9, 24'hFFFFFF, 24'hABCDEF, 1'b1, "rd_r15_r9");

        cyc(1'b1, 4'd1, 24'h000042, 1'b0, 4'd0, 1'b0, 4'd0, 24'hFFFFFF, 24'hABCDEF, 1'b1, "wr_r1");
        cyc(1'b0, 4'd0, 24'h0, 1'b1, 4'd1, 1'b0, 4'd0, 24'h000042, 24'hABCDEF, 1'b1, "rd_r1");

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_ready", {31'h0, rdy}, 32'h0);
        chk("midrun_rst_rd_a", {8'h0, da}, 32'h0);
        chk("midrun_rst_rd_b", {8'h0, db}, 32'h0);

        init_seq("reinit", 1'b0);
        cyc(1'b0, 4'd0, 24'h0, 1'b1, 4'd1, 1'b1, 4'd15, 24'h0, 24'h0, 1'b1, "post_r1_r15");
        cyc(1'b0, 4'd0, 24'h0, 1'b1, 4'd7, 1'b1, 4'd0, 24'h0, 24'h0, 1'b1, "post_r7_r0");

        repeat (3) @(posedge clk);
        #3;
        chk("sb_drain", sb.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
